// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched by key_idx from an external store.
// Define AES_INV_CIPHER_ITER_ROUND_OUT_EN to expose the round state (dbg_state) and a per-round strobe (dbg_valid).
module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         ready,
  output logic         busy,
  output logic [127:0] plaintext,
  output logic         done
`ifdef AES_INV_CIPHER_ITER_ROUND_OUT_EN
  ,
  output logic [127:0] dbg_state,
  output logic         dbg_valid
`endif
);

  typedef enum logic {IDLE, RUN} fsm_t;

  // Row 0 of the table holds entries 0x00..0x0f. Entry b therefore sits at bit offset (255-b)*8.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  fsm_t         fsm, fsm_next;
  logic [3:0]   rnd;
  logic [127:0] state_reg;
  logic [127:0] shifted, subbed, added, mixed;
  logic         accept, final_round;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_SBOX[idx +: 8];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Each column is multiplied by the circulant {0e,0b,0d,09}; the multiples are built from repeated doubling.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

  assign shifted     = inv_shift_rows(state_reg);
  assign subbed      = inv_sub_bytes(shifted);
  assign added       = subbed ^ round_key;
  assign mixed       = inv_mix_columns(added);
  assign accept      = (fsm == IDLE) && start;
  assign final_round = (fsm == RUN) && (rnd == 4'd0);
  assign busy        = ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    ready    = 1'b0;
    key_idx  = rnd;
    case (fsm)
      IDLE: begin
        ready   = 1'b1;
        key_idx = 4'd10;
        if (start) fsm_next = RUN;
      end
      RUN: if (rnd == 4'd0) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // The done cycle is already IDLE, so a start held there is accepted with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd       <= 4'd0;
      state_reg <= '0;
      plaintext <= '0;
      done      <= 1'b0;
    end else begin
      done <= final_round;
      if (accept) begin
        state_reg <= ciphertext ^ round_key;
        rnd       <= 4'd9;
      end else if (fsm == RUN && rnd != 4'd0) begin
        state_reg <= mixed;
        rnd       <= rnd - 4'd1;
      end
      if (final_round) plaintext <= added;
    end
  end

`ifdef AES_INV_CIPHER_ITER_ROUND_OUT_EN
  assign dbg_state = state_reg;
  assign dbg_valid = (fsm == RUN);
`endif

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors; round keys come from a local key-expansion model.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         ready, busy, done;
  logic [127:0] plaintext;
`ifdef AES_INV_CIPHER_ITER_ROUND_OUT_EN
  logic [127:0] dbg_state;
  logic         dbg_valid;
`endif

  logic [127:0] rk_tab [0:10];
  int           assert_cnt = 0;
  int           fail_cnt = 0;

  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_ZERO  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C1    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  assign round_key = (key_idx <= 4'd10) ? rk_tab[key_idx] : 128'h0;

  aes_inv_cipher_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ciphertext (ciphertext),
    .key_idx    (key_idx),
    .round_key  (round_key),
    .ready      (ready),
    .busy       (busy),
    .plaintext  (plaintext),
    .done       (done)
`ifdef AES_INV_CIPHER_ITER_ROUND_OUT_EN
    ,
    .dbg_state  (dbg_state),
    .dbg_valid  (dbg_valid)
`endif
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from first principles: multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gf_mul(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_fwd(t[31:24]), sbox_fwd(t[23:16]), sbox_fwd(t[15:8]), sbox_fwd(t[7:0])} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assert_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Runs one block with the key currently in rk_tab. With prelaunched set, start/ciphertext are already driven
  // for the coming edge. With have_next set, the next block is launched from the done cycle.
  task automatic applyStimulus(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt,
                               input bit prelaunched, input bit check_kseq, input bit noise,
                               input bit have_next, input logic [127:0] next_key, input logic [127:0] next_ct);
    logic [3:0]   kseq [0:11];
    logic [127:0] rk10;
    int           n, edges, valid_cnt;
    bit           got;
    if (!prelaunched) begin
      @(negedge clk);
      ciphertext = ct;
      start = 1'b1;
    end
    rk10 = rk_tab[10];
    kseq[0] = key_idx;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    kseq[1] = key_idx;
    checkOutput({tag, "_ready_busy_run"}, 128'({ready, busy}), 128'b01);
    valid_cnt = 0;
`ifdef AES_INV_CIPHER_ITER_ROUND_OUT_EN
    checkOutput({tag, "_dbg_state_e0"}, dbg_state, ct ^ rk10);
    if (dbg_valid) valid_cnt++;
`endif
    n = 2;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
`ifdef AES_INV_CIPHER_ITER_ROUND_OUT_EN
      if (dbg_valid) valid_cnt++;
`endif
      if (done) got = 1'b1;
      else if (n < 12) begin
        kseq[n] = key_idx;
        n++;
      end
      if (noise && edges == 4) begin
        start = 1'b1;
        ciphertext = ~ct;
      end else if (noise && edges == 5) begin
        start = 1'b0;
      end
    end
    checkOutput({tag, "_latency"}, got ? 128'(edges) : 128'(0), 128'(10));
    checkOutput({tag, "_plaintext"}, plaintext, exp_pt);
    checkOutput({tag, "_ready_in_done"}, 128'(ready), 128'(1));
    if (check_kseq)
      for (int i = 0; i < 11; i++)
        checkOutput($sformatf("%s_key_idx_%0d", tag, i), 128'(kseq[i]), 128'(10 - i));
`ifdef AES_INV_CIPHER_ITER_ROUND_OUT_EN
    checkOutput({tag, "_dbg_valid_cycles"}, 128'(valid_cnt), 128'(10));
`endif
    if (have_next) begin
      expand_key(next_key);
      ciphertext = next_ct;
      start = 1'b1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_done_single"}, 128'(done), 128'(0));
      checkOutput({tag, "_plaintext_held"}, plaintext, exp_pt);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_seen;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_ready", 128'(ready), 128'(1));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_key_idx", 128'(key_idx), 128'(10));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_plaintext", plaintext, 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // For the all-zero key, the first expanded round key is the well-known 6263... pattern.
    expand_key(KEY_ZERO);
    checkOutput("zero_key_rk1", rk_tab[1], 128'h62636363626363636263636362636363);
    applyStimulus("zero_key", CT_ZERO, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    expand_key(KEY_C1);
    applyStimulus("fips_c1", CT_C1, PT_C1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    expand_key(KEY_B);
    applyStimulus("fips_b", CT_B, PT_B, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

    expand_key(KEY_C1);
    applyStimulus("b2b_first", CT_C1, PT_C1, 1'b0, 1'b0, 1'b0, 1'b1, KEY_B, CT_B);
    applyStimulus("b2b_second", CT_B, PT_B, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);

    expand_key(KEY_ZERO);
    @(negedge clk);
    ciphertext = CT_ZERO;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_ready", 128'(ready), 128'(1));
    checkOutput("midrun_rst_busy", 128'(busy), 128'(0));
    checkOutput("midrun_rst_key_idx", 128'(key_idx), 128'(10));
    checkOutput("midrun_rst_done", 128'(done), 128'(0));
    checkOutput("midrun_rst_plaintext", plaintext, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("midrun_no_done", 128'(done_seen), 128'(0));
    checkOutput("midrun_plaintext_zero", plaintext, 128'h0);

    // Start is raised together with the reset release so the very first edge must accept it.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    expand_key(KEY_B);
    rst_n = 1'b1;
    ciphertext = CT_B;
    start = 1'b1;
    applyStimulus("post_reset", CT_B, PT_B, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
